// File: rtl/set_min_delay_pkg.sv
// Shared types and default sizes for the set_min_delay_pipe datapath.
// Optional feature macro used elsewhere: SET_MIN_DELAY_PIPE_PARITY_EN.
package set_min_delay_pkg;

  // Flush/drain controller states.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_DEPTH  = 3;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/set_min_delay_stage.sv
// One pipeline stage: a data register plus its valid bit.
// The valid and data enables are separate so the launch stage can load
// data only on an accepted word while still shifting a bubble on advance.
module set_min_delay_stage
  import set_min_delay_pkg::*;
#(
  parameter int DW = DEF_WIDTH * DEF_NUM_CH
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          v_en,
  input  logic          d_en,
  input  logic [DW-1:0] d_in,
  input  logic          v_in,
  output logic [DW-1:0] d_out,
  output logic          v_out
);

  // Stage register with asynchronous clear.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      d_out <= '0;
      v_out <= 1'b0;
    end else begin
      if (v_en) v_out <= v_in;
      if (d_en) d_out <= d_in;
    end
  end

endmodule

// File: rtl/set_min_delay_pipe.sv
// set_min_delay_pipe: NUM_CH x WIDTH launch -> pad stages -> capture path
// with inverted capture feedback, valid/ready handshake, flush/drain FSM
// and a saturating transfer counter. Single clock domain (clk1).
// Optional: define SET_MIN_DELAY_PIPE_PARITY_EN to add port2_par, the even
// parity of each captured channel, registered alongside port2.
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. Ready never depends on the same interface's
// valid; valid holds its word until it is taken.
module set_min_delay_pipe
  import set_min_delay_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk1,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] port1,
  input  logic                    port1_valid,
  output logic                    port1_ready,
  output logic [NUM_CH*WIDTH-1:0] port2,
  output logic                    port2_valid,
  input  logic                    port2_ready,
  input  logic                    mode,
  input  logic                    flush,
  output logic                    flush_done,
  output logic [CNT_W-1:0]        xfer_cnt,
`ifdef SET_MIN_DELAY_PIPE_PARITY_EN
  output logic [NUM_CH-1:0]       port2_par,
`endif
  output state_e                  state_dbg
);

  localparam int DW = NUM_CH * WIDTH;

  logic                      adv;
  logic                      accept;
  logic                      empty;
  logic [DW-1:0]             fb;
  logic [DW-1:0]             launch_d;
  logic [DEPTH-1:0][DW-1:0]  s_d;
  logic [DEPTH-1:0]          s_v;
  logic [DEPTH-1:0][DW-1:0]  s_in_d;
  logic [DEPTH-1:0]          s_in_v;
  logic [DEPTH-1:0]          s_d_en;
  state_e                    state;
  state_e                    state_nxt;

  // The whole pipe moves as one: it advances unless the output is held.
  assign adv         = !port2_valid || port2_ready;
  assign port1_ready = adv && (state == RUN);
  assign accept      = port1_valid && port1_ready;
  assign empty       = (s_v == '0) && !port2_valid;

  // Feedback masks every channel bit-for-bit, so a whole-vector AND is
  // the same as the per-channel form.
  assign launch_d = mode ? port1 : (port1 & fb);

  // Stage input steering: stage 0 takes the launch word, later stages
  // copy their predecessor on every advance.
  always_comb begin
    s_in_d    = '0;
    s_in_v    = '0;
    s_d_en    = '0;
    s_in_d[0] = launch_d;
    s_in_v[0] = accept;
    s_d_en[0] = accept;
    for (int i = 1; i < DEPTH; i++) begin
      s_in_d[i] = s_d[i-1];
      s_in_v[i] = s_v[i-1];
      s_d_en[i] = adv;
    end
  end

  // stg[i].u_reg names are kept stable for timing-constraint targets.
  for (genvar i = 0; i < DEPTH; i++) begin : stg
    set_min_delay_stage #(.DW(DW)) u_reg (
      .clk1  (clk1),
      .rst   (rst),
      .v_en  (adv),
      .d_en  (s_d_en[i]),
      .d_in  (s_in_d[i]),
      .v_in  (s_in_v[i]),
      .d_out (s_d[i]),
      .v_out (s_v[i])
    );
  end

`ifdef SET_MIN_DELAY_PIPE_PARITY_EN
  logic [NUM_CH-1:0] par_nxt;

  // Even parity of each channel of the word about to be captured.
  always_comb begin
    par_nxt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      par_nxt[c] = ^s_d[DEPTH-1][c*WIDTH +: WIDTH];
    end
  end

  // Parity shares the capture enable so it always matches port2.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      port2_par <= '0;
    end else if (adv && s_v[DEPTH-1]) begin
      port2_par <= par_nxt;
    end
  end
`endif

  // Capture register and inverted feedback; the launch stage sees the
  // feedback value from before this edge.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      port2       <= '0;
      port2_valid <= 1'b0;
      fb          <= '1;
    end else if (adv) begin
      port2_valid <= s_v[DEPTH-1];
      if (s_v[DEPTH-1]) begin
        port2 <= s_d[DEPTH-1];
        fb    <= ~s_d[DEPTH-1];
      end
    end
  end

  // Output handshake counter that sticks at its maximum.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (port2_valid && port2_ready && (xfer_cnt != '1)) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  // Flush controller state register.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Flush controller next state: once draining starts it runs to empty
  // regardless of flush; a flush seen in DONE starts a fresh drain.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush) state_nxt = DRAIN;
      DRAIN:   if (empty) state_nxt = DONE;
      DONE:    state_nxt = flush ? DRAIN : RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign flush_done = (state == DONE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_set_min_delay_pipe.sv
// Self-checking bench for set_min_delay_pipe (default sizes, plus a
// CNT_W=2 instance sharing the same stimulus for counter saturation).
// Honours SET_MIN_DELAY_PIPE_PARITY_EN when defined.
module tb_set_min_delay_pipe;
  import set_min_delay_pkg::*;

  localparam int DW = 16;

  logic          clk1 = 1'b0;
  logic          rst;
  logic [DW-1:0] port1;
  logic          port1_valid;
  logic          port1_ready;
  logic [DW-1:0] port2;
  logic          port2_valid;
  logic          port2_ready;
  logic          mode;
  logic          flush;
  logic          flush_done;
  logic [15:0]   xfer_cnt;
  state_e        state_dbg;

  logic          sat_port1_ready;
  logic [DW-1:0] sat_port2;
  logic          sat_port2_valid;
  logic          sat_flush_done;
  logic [1:0]    sat_xfer_cnt;
  state_e        sat_state_dbg;
`ifdef SET_MIN_DELAY_PIPE_PARITY_EN
  logic [1:0]    port2_par;
  logic [1:0]    sat_port2_par;
`endif

  logic [DW-1:0] exp_q[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  int            hs_cnt = 0;
  logic          drv_done;

  // ---------------- clock / reset ----------------
  always #5 clk1 = ~clk1;

  set_min_delay_pipe dut (
    .clk1        (clk1),
    .rst         (rst),
    .port1       (port1),
    .port1_valid (port1_valid),
    .port1_ready (port1_ready),
    .port2       (port2),
    .port2_valid (port2_valid),
    .port2_ready (port2_ready),
    .mode        (mode),
    .flush       (flush),
    .flush_done  (flush_done),
    .xfer_cnt    (xfer_cnt),
`ifdef SET_MIN_DELAY_PIPE_PARITY_EN
    .port2_par   (port2_par),
`endif
    .state_dbg   (state_dbg)
  );

  set_min_delay_pipe #(.CNT_W(2)) u_sat (
    .clk1        (clk1),
    .rst         (rst),
    .port1       (port1),
    .port1_valid (port1_valid),
    .port1_ready (sat_port1_ready),
    .port2       (sat_port2),
    .port2_valid (sat_port2_valid),
    .port2_ready (port2_ready),
    .mode        (mode),
    .flush       (flush),
    .flush_done  (sat_flush_done),
    .xfer_cnt    (sat_xfer_cnt),
`ifdef SET_MIN_DELAY_PIPE_PARITY_EN
    .port2_par   (sat_port2_par),
`endif
    .state_dbg   (sat_state_dbg)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one word, wait (bounded) for acceptance, then queue its
  // hand-computed expected output. Returns 1ns after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] e);
    int t;
    t = 0;
    port1       = d;
    port1_valid = 1'b1;
    @(negedge clk1);
    while (!port1_ready && t < 60) begin
      t++;
      @(negedge clk1);
    end
    if (!port1_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: word %0h not accepted within 60 cycles", d);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk1);
    #1;
    port1_valid = 1'b0;
  endtask

  task automatic wait_empty(input int max_cyc);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < max_cyc) begin
      @(negedge clk1);
      t++;
    end
    @(negedge clk1);
    check("queue_drained", exp_q.size(), 0);
    @(posedge clk1);
    #1;
  endtask

  task automatic wait_drv(input int max_cyc);
    int t;
    t = 0;
    while (!drv_done && t < max_cyc) begin
      @(negedge clk1);
      t++;
    end
    check("driver_done", drv_done, 1'b1);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [DW-1:0] e;
    forever begin
      @(negedge clk1);
      if (!rst && port2_valid && port2_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", port2);
        end else begin
          e = exp_q.pop_front();
          check("port2_data", port2, e);
        end
`ifdef SET_MIN_DELAY_PIPE_PARITY_EN
        check("port2_par", port2_par, {^port2[15:8], ^port2[7:0]});
`endif
        check("xfer_cnt", xfer_cnt, hs_cnt);
        check("xfer_cnt_sat", sat_xfer_cnt, (hs_cnt > 3) ? 3 : hs_cnt);
        hs_cnt++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int pulses;
    logic seen_done;

    rst = 1'b1; port1 = '0; port1_valid = 1'b0; port2_ready = 1'b1;
    mode = 1'b0; flush = 1'b0; drv_done = 1'b0;
    repeat (3) @(posedge clk1);
    #1;
    check("rst_port2", port2, 16'h0000);
    check("rst_port2_valid", port2_valid, 1'b0);
    check("rst_xfer_cnt", xfer_cnt, 16'h0000);
    check("rst_flush_done", flush_done, 1'b0);
    check("rst_state", state_dbg, RUN);
    rst = 1'b0;
    @(negedge clk1);
    check("idle_port1_ready", port1_ready, 1'b1);
    @(posedge clk1);
    #1;

    // 1. mode 0: fb starts all ones, so FF/FF passes; it appears after 3 edges.
    send(16'hFFFF, 16'hFFFF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk1);
      check("latency_not_yet", port2_valid, 1'b0);
    end
    @(negedge clk1);
    check("latency_arrive", port2_valid, 1'b1);
    wait_empty(20);
    // fb is now ~FFFF = 0000, masking the next word entirely.
    send(16'h0FF0, 16'h0000);
    wait_empty(20);
    // fb = FFFF. Five words back-to-back: w3 launches on the edge that
    // captures w0 and still sees the old fb; w4 sees ~w0 = 5AC3.
    send(16'hA53C, 16'hA53C);
    send(16'h0FF0, 16'h0FF0);
    send(16'hAA55, 16'hAA55);
    send(16'h7E81, 16'h7E81);
    send(16'hFFFF, 16'h5AC3);
    wait_empty(30);

    // 2. mode 1: feedback bypassed.
    mode = 1'b1;
    send(16'hFFFF, 16'hFFFF);
    send(16'h0FF0, 16'h0FF0);
    send(16'h0007, 16'h0007);
    wait_empty(30);

    // 3. Stall with the pipe full, then release.
    port2_ready = 1'b0;
    drv_done = 1'b0;
    fork
      begin
        send(16'h1101, 16'h1101);
        send(16'h2202, 16'h2202);
        send(16'h3303, 16'h3303);
        send(16'h4404, 16'h4404);
        send(16'h5505, 16'h5505);
        send(16'h6606, 16'h6606);
        drv_done = 1'b1;
      end
    join_none
    repeat (10) @(negedge clk1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk1);
      check("stall_port1_ready", port1_ready, 1'b0);
      check("stall_port2_valid", port2_valid, 1'b1);
      check("stall_port2", port2, 16'h1101);
    end
    @(posedge clk1);
    #1;
    port2_ready = 1'b1;
    wait_drv(100);
    wait_empty(40);

    // 4. Four words in flight, one-cycle flush; a fifth word waits for RUN.
    send(16'hC001, 16'hC001);
    send(16'hC002, 16'hC002);
    send(16'hC003, 16'hC003);
    send(16'hC004, 16'hC004);
    flush = 1'b1;
    @(posedge clk1);
    #1;
    flush = 1'b0;
    drv_done = 1'b0;
    fork
      begin
        send(16'hBEEF, 16'hBEEF);
        drv_done = 1'b1;
      end
    join_none
    pulses = 0;
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk1);
      if (flush_done) begin
        pulses++;
        seen_done = 1'b1;
      end else if (!seen_done) begin
        check("drain_port1_ready", port1_ready, 1'b0);
      end
    end
    check("flush_done_pulses", pulses, 1);
    check("state_after_flush", state_dbg, RUN);
    wait_drv(40);
    wait_empty(40);

    // 5. Narrow counter is saturated by now; then reset mid-stall.
    check("sat_counter_hold", sat_xfer_cnt, 2'd3);
    port2_ready = 1'b0;
    drv_done = 1'b0;
    fork
      begin
        send(16'hD001, 16'hD001);
        send(16'hD002, 16'hD002);
        send(16'hD003, 16'hD003);
        drv_done = 1'b1;
      end
    join_none
    wait_drv(40);
    repeat (3) @(negedge clk1);
    check("pre_rst_port2_valid", port2_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_port2", port2, 16'h0000);
    check("async_rst_port2_valid", port2_valid, 1'b0);
    check("async_rst_xfer_cnt", xfer_cnt, 16'h0000);
    check("async_rst_sat_cnt", sat_xfer_cnt, 2'd0);
    check("async_rst_state", state_dbg, RUN);
    exp_q.delete();
    hs_cnt = 0;
    @(posedge clk1);
    #1;
    rst = 1'b0;
    port2_ready = 1'b1;
    // fb is back to all ones, so a mode-0 word passes unchanged.
    mode = 1'b0;
    send(16'h1234, 16'h1234);
    wait_empty(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
